// File: rtl/perf_dump_reader.sv
// perf_dump_reader: reads NUM_WORDS consecutive 32-bit words from a performance counter
// debug window and streams them out as bytes, MSB first, behind an 8'hA5 header byte.
// Optional macro PERF_DUMP_CHECKSUM_EN appends an XOR checksum byte over all data bytes.
module perf_dump_reader #(
  parameter logic [31:0] PERF_BASE = 32'h3000_0000,
  parameter int unsigned NUM_WORDS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [31:0] debug_addr,
  output logic        debug_read,
  input  logic [31:0] debug_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] HEADER = 3'd1;
  localparam logic [2:0] READ   = 3'd2;
  localparam logic [2:0] SEND   = 3'd3;
  localparam logic [2:0] CKSUM  = 3'd4;
  localparam logic [2:0] FINISH = 3'd5;

  localparam logic [3:0] LAST_IDX = 4'(NUM_WORDS - 1);

  logic [2:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [1:0]  byte_q, byte_d;
  logic [31:0] word_q, word_d;
  logic        xfer;

`ifdef PERF_DUMP_CHECKSUM_EN
  logic [7:0] cksum_q, cksum_d;
`endif

  assign xfer = tx_valid & tx_ready;

  // Next-state and datapath updates; tx_data is only consumed on a completed transfer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    byte_d  = byte_q;
    word_d  = word_q;
`ifdef PERF_DUMP_CHECKSUM_EN
    cksum_d = cksum_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = HEADER;
          idx_d   = 4'd0;
          byte_d  = 2'd0;
`ifdef PERF_DUMP_CHECKSUM_EN
          cksum_d = 8'h00;
`endif
        end
      end
      HEADER: begin
        if (tx_ready) state_d = READ;
      end
      READ: begin
        word_d  = debug_data;
        byte_d  = 2'd0;
        state_d = SEND;
      end
      SEND: begin
        if (tx_ready) begin
          byte_d = byte_q + 2'd1;
`ifdef PERF_DUMP_CHECKSUM_EN
          cksum_d = cksum_q ^ tx_data;
`endif
          if (byte_q == 2'd3) begin
            if (idx_q != LAST_IDX) begin
              idx_d   = idx_q + 4'd1;
              state_d = READ;
            end else begin
`ifdef PERF_DUMP_CHECKSUM_EN
              state_d = CKSUM;
`else
              state_d = FINISH;
`endif
            end
          end
        end
      end
      CKSUM: begin
        // Unreachable without the checksum build.
        if (tx_ready) state_d = FINISH;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      byte_q  <= 2'd0;
      word_q  <= 32'h0;
`ifdef PERF_DUMP_CHECKSUM_EN
      cksum_q <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      word_q  <= word_d;
`ifdef PERF_DUMP_CHECKSUM_EN
      cksum_q <= cksum_d;
`endif
    end
  end

  // Outputs decoded from registered state, so they stay stable through tx stalls.
  always_comb begin
    tx_data    = 8'h00;
    tx_valid   = 1'b0;
    debug_read = 1'b0;
    debug_addr = 32'h0;
    case (state_q)
      HEADER: begin
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
      end
      READ: begin
        debug_read = 1'b1;
        debug_addr = PERF_BASE + {26'd0, idx_q, 2'b00};
      end
      SEND: begin
        tx_valid = 1'b1;
        case (byte_q)
          2'd0:    tx_data = word_q[31:24];
          2'd1:    tx_data = word_q[23:16];
          2'd2:    tx_data = word_q[15:8];
          default: tx_data = word_q[7:0];
        endcase
      end
      CKSUM: begin
        tx_valid = 1'b1;
`ifdef PERF_DUMP_CHECKSUM_EN
        tx_data  = cksum_q;
`endif
      end
      default: ;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == FINISH);

endmodule

// File: tb/tb_perf_dump_reader.sv
// Directed bench for perf_dump_reader (honours PERF_DUMP_CHECKSUM_EN if defined).
module tb_perf_dump_reader;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int NW = 6;
  localparam int LIMIT = 400;
`ifdef PERF_DUMP_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] debug_addr;
  logic        debug_read;
  logic [31:0] debug_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;

  int checks = 0;
  int fails  = 0;

  logic [7:0]  bytes_q[$];
  logic [31:0] addrs_q[$];
  logic [7:0]  exp_q[$];
  int          done_cnt;
  int          stab_err;
  logic        ready_mode;
  int          rcnt;

  perf_dump_reader #(.PERF_BASE(BASE), .NUM_WORDS(NW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .debug_addr(debug_addr),
    .debug_read(debug_read),
    .debug_data(debug_data),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter responder: word k at BASE+4k reads as {4{(k+1)*8'h11}}.
  logic [31:0] off;
  logic [7:0]  kidx;
  logic [7:0]  rbyte;
  always_comb begin
    off        = debug_addr - BASE;
    kidx       = off[9:2];
    rbyte      = (kidx + 8'd1) * 8'h11;
    debug_data = debug_read ? {4{rbyte}} : 32'hDEAD_BEEF;
  end

  // Sink ready: either always 1, or the 0,0,1 stall pattern.
  always @(posedge clk) begin
    #1;
    if (ready_mode) begin
      tx_ready = (rcnt == 2);
      rcnt = (rcnt == 2) ? 0 : rcnt + 1;
    end else begin
      tx_ready = 1'b1;
    end
  end

  // Monitor on the falling edge: transfers, reads, done pulses, stall stability.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  always @(negedge clk) begin
    if (rst) begin
      if (tx_valid && tx_ready) bytes_q.push_back(tx_data);
      if (debug_read) addrs_q.push_back(debug_addr);
      if (done) done_cnt++;
      if (prev_stall && (!tx_valid || tx_data != prev_data)) stab_err++;
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic build_expected();
    logic [7:0] b;
    logic [7:0] x;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    x = 8'h00;
    for (int w = 0; w < NW; w++) begin
      b = 8'((w + 1) * 17);
      for (int k = 0; k < 4; k++) begin
        exp_q.push_back(b);
        x = x ^ b;
      end
    end
    if (CK == 1) exp_q.push_back(x);
  endtask

  task automatic clear_mon();
    bytes_q.delete();
    addrs_q.delete();
    done_cnt = 0;
    stab_err = 0;
  endtask

  // Pulse start for one cycle, then count busy cycles until IDLE re-entry.
  task automatic run_dump(output int cycles);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 0;
    while (busy && cycles < LIMIT) begin
      cycles++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic compare_stream(input string name);
    checks++;
    if (bytes_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL %s byte_count: got %0d expected %0d", name, bytes_q.size(), exp_q.size());
    end
    for (int i = 0; i < bytes_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (bytes_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL %s byte[%0d]: got %02h expected %02h", name, i, bytes_q[i], exp_q[i]);
      end
    end
    checks++;
    if (addrs_q.size() != NW) begin
      fails++;
      $display("FAIL %s read_count: got %0d expected %0d", name, addrs_q.size(), NW);
    end
    for (int i = 0; i < addrs_q.size() && i < NW; i++) begin
      checks++;
      if (addrs_q[i] !== BASE + 32'(4 * i)) begin
        fails++;
        $display("FAIL %s addr[%0d]: got %08h expected %08h", name, i, addrs_q[i],
                 BASE + 32'(4 * i));
      end
    end
    checks++;
    if (done_cnt != 1) begin
      fails++;
      $display("FAIL %s done_pulses: got %0d expected 1", name, done_cnt);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00 || debug_read !== 1'b0 ||
        debug_addr !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL %s outputs: got v=%b d=%02h rd=%b a=%08h busy=%b done=%b expected all 0",
               name, tx_valid, tx_data, debug_read, debug_addr, busy, done);
    end
  endtask

  task automatic test_reset();
    #3 rst = 1'b0;
    #1;
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("post_reset_idle");
  endtask

  task automatic test_basic_dump();
    int cyc;
    clear_mon();
    ready_mode = 1'b0;
    run_dump(cyc);
    compare_stream("basic");
    checks++;
    if (cyc != 1 + NW * 5 + CK + 1) begin
      fails++;
      $display("FAIL basic cycles: got %0d expected %0d", cyc, 1 + NW * 5 + CK + 1);
    end
  endtask

  task automatic test_stall();
    int cyc;
    clear_mon();
    rcnt = 0;
    ready_mode = 1'b1;
    run_dump(cyc);
    ready_mode = 1'b0;
    compare_stream("stall");
    checks++;
    if (cyc >= LIMIT) begin
      fails++;
      $display("FAIL stall timeout: got %0d cycles expected < %0d", cyc, LIMIT);
    end
    checks++;
    if (stab_err != 0) begin
      fails++;
      $display("FAIL stall stability: got %0d violations expected 0", stab_err);
    end
  endtask

  task automatic test_start_held();
    int n;
    clear_mon();
    @(posedge clk); #1;
    start = 1'b1;
    n = 0;
    @(negedge clk);
    while (!done && n < LIMIT) begin
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL start_held idle_after_done: got busy=%b expected 0", busy);
    end
    @(posedge clk); #1;
    checks++;
    if (bytes_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL start_held byte_count: got %0d expected %0d", bytes_q.size(), exp_q.size());
    end
    checks++;
    if (addrs_q.size() != NW) begin
      fails++;
      $display("FAIL start_held read_count: got %0d expected %0d", addrs_q.size(), NW);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int cyc;
    clear_mon();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    @(negedge clk);
    while (!(debug_read && debug_addr == BASE + 32'd12) && n < LIMIT) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n >= LIMIT) begin
      fails++;
      $display("FAIL reset_mid reach_word3: got timeout expected read of %08h", BASE + 32'd12);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid in_send: got v=%b busy=%b expected 1 1", tx_valid, busy);
    end
    #2 rst = 1'b0;
    #1;
    check_idle_outputs("reset_mid_async");
    @(posedge clk); #1;
    rst = 1'b1;
    clear_mon();
    run_dump(cyc);
    checks++;
    if (bytes_q.size() == 0 || bytes_q[0] !== 8'hA5) begin
      fails++;
      $display("FAIL reset_mid first_byte: got %02h expected a5",
               bytes_q.size() > 0 ? bytes_q[0] : 8'h00);
    end
    compare_stream("after_reset");
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    tx_ready   = 1'b1;
    ready_mode = 1'b0;
    rcnt       = 0;
    done_cnt   = 0;
    stab_err   = 0;
    build_expected();
    test_reset();
    test_basic_dump();
    test_stall();
    test_start_held();
    test_reset_mid();
    test_basic_dump();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
